// File: rtl/mem_gen_bank_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_gen_bank_ctrl_if
// Request/response bus between a client datapath and mem_gen_bank_ctrl.
//
// Handshake (both channels): a transfer happens on a rising edge where
// valid & ready are both high. Once valid is raised, the source holds it and
// its payload stable until the transfer. ready may be raised or lowered
// freely and never depends combinationally on valid.
//
// Signals:
//   req_valid / req_ready  request channel handshake (client -> controller)
//   req_wr                 1 = write, 0 = read
//   req_addr               word address
//   req_wdata              write data
//   rsp_valid / rsp_ready  response channel handshake (controller -> client)
//   rsp_data               read data, in request order
// Modports: master = client side, slave = controller side.
// ---------------------------------------------------------------------------
interface mem_gen_bank_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mem_gen_bank_ctrl.sv
// ---------------------------------------------------------------------------
// mem_gen_bank_ctrl
// Banked, word-interleaved memory controller. Accepts read/write requests on
// a valid/ready port, returns read data through a credit-limited pipeline
// and response FIFO, and clears the whole array after every reset.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      synchronous active-low reset
//   bus          mem_gen_bank_ctrl_if.slave (request + response channels)
//   init_done    high once the post-reset clear sweep has finished
//   rsp_perr     parity mismatch on rsp_data (only with MEM_GEN_PARITY_EN)
//   dbg_state_o  FSM state: 0 = INIT (clear sweep), 1 = RUN
//
// Build option: define MEM_GEN_PARITY_EN to store an even-parity bit with
// each word and report mismatches on rsp_perr.
// ---------------------------------------------------------------------------
module mem_gen_bank_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int NUM_BANKS = 4,
  parameter int RD_LAT    = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  mem_gen_bank_ctrl_if.slave bus,
  output logic               init_done,
`ifdef MEM_GEN_PARITY_EN
  output logic               rsp_perr,
`endif
  output logic               dbg_state_o
);
  localparam int LOG_NB     = $clog2(NUM_BANKS);
  localparam int BSEL_W     = (NUM_BANKS > 1) ? LOG_NB : 1;
  localparam int IDX_W      = ADDR_W - LOG_NB;
  localparam int BANK_DEPTH = 2 ** IDX_W;
  localparam int RSP_DEPTH  = RD_LAT + 1;
  localparam int PTR_W      = $clog2(RSP_DEPTH);
  localparam int CNT_W      = $clog2(RSP_DEPTH + 1);
`ifdef MEM_GEN_PARITY_EN
  localparam int MEM_W      = DATA_W + 1;
`else
  localparam int MEM_W      = DATA_W;
`endif

  // ---------------- FSM: clear sweep, then run ----------------
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      ST_INIT: begin
        sweep_idx_d = sweep_idx_q + IDX_W'(1);
        if (sweep_idx_q == IDX_W'(BANK_DEPTH - 1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  assign init_done   = (state_q == ST_RUN);
  assign dbg_state_o = (state_q == ST_RUN);

  // ---------------- credits ----------------
  // Every outstanding read (in the pipe or waiting in the FIFO) holds one
  // FIFO slot, so the FIFO can never overflow. Only registers feed req_ready.
  logic [RD_LAT-1:0] pipe_vld_q;
  logic [CNT_W-1:0]  fifo_cnt_q;
  logic [CNT_W:0]    used;

  always_comb begin
    used = (CNT_W+1)'(fifo_cnt_q);
    for (int k = 0; k < RD_LAT; k++) used = used + (CNT_W+1)'(pipe_vld_q[k]);
  end

  assign bus.req_ready = (state_q == ST_RUN) && (used < (CNT_W+1)'(RSP_DEPTH));

  // ---------------- request decode ----------------
  logic              acc, acc_rd;
  logic [BSEL_W-1:0] req_bank;
  logic [IDX_W-1:0]  req_idx;
  logic [MEM_W-1:0]  wr_word;

  assign acc      = bus.req_valid & bus.req_ready;
  assign acc_rd   = acc & ~bus.req_wr;
  // Low address bits select the bank; the mask makes a 1-bank build use bank 0.
  assign req_bank = BSEL_W'(bus.req_addr) & BSEL_W'(NUM_BANKS - 1);
  assign req_idx  = bus.req_addr[ADDR_W-1:LOG_NB];
`ifdef MEM_GEN_PARITY_EN
  assign wr_word  = {^bus.req_wdata, bus.req_wdata};
`else
  assign wr_word  = bus.req_wdata;
`endif

  // ---------------- bank control ----------------
  // The sweep enables all banks at once; a normal access enables only one.
  logic [NUM_BANKS-1:0] bank_en, bank_we;
  logic [IDX_W-1:0]     bank_idx;
  logic [MEM_W-1:0]     bank_wdata;

  always_comb begin
    bank_en    = '0;
    bank_we    = '0;
    bank_idx   = req_idx;
    bank_wdata = wr_word;
    if (reset_n && state_q == ST_INIT) begin
      bank_en    = '1;
      bank_we    = '1;
      bank_idx   = sweep_idx_q;
      bank_wdata = '0;
    end else if (acc) begin
      bank_en[req_bank] = 1'b1;
      bank_we[req_bank] = bus.req_wr;
    end
  end

  logic [MEM_W-1:0] mem_q        [NUM_BANKS][BANK_DEPTH];
  logic [MEM_W-1:0] bank_rdata_q [NUM_BANKS];

  always_ff @(posedge clock) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_en[b]) begin
        if (bank_we[b]) mem_q[b][bank_idx] <= bank_wdata;
        else            bank_rdata_q[b]    <= mem_q[b][bank_idx];
      end
    end
  end

  // ---------------- read pipeline ----------------
  // Stage 0 is the bank output register; further stages pad the latency so
  // a read accepted at edge N lands in the FIFO at edge N+RD_LAT.
  logic [BSEL_W-1:0] rd_bank_q;
  logic [MEM_W-1:0]  stage_data [RD_LAT];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= acc_rd;
      for (int k = 1; k < RD_LAT; k++) pipe_vld_q[k] <= pipe_vld_q[k-1];
    end
  end

  always_ff @(posedge clock) begin
    if (acc_rd) rd_bank_q <= req_bank;
  end

  assign stage_data[0] = bank_rdata_q[rd_bank_q];

  for (genvar k = 1; k < RD_LAT; k++) begin : g_pipe
    logic [MEM_W-1:0] data_q;
    always_ff @(posedge clock) data_q <= stage_data[k-1];
    assign stage_data[k] = data_q;
  end

  // ---------------- response FIFO ----------------
  logic [DATA_W-1:0] fifo_data_q [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic              push, pop;
  logic [MEM_W-1:0]  push_word;

  assign push          = pipe_vld_q[RD_LAT-1];
  assign push_word     = stage_data[RD_LAT-1];
  assign bus.rsp_valid = (fifo_cnt_q != '0);
  assign pop           = bus.rsp_valid & bus.rsp_ready;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
      else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
    end
  end

`ifdef MEM_GEN_PARITY_EN
  logic [RSP_DEPTH-1:0] fifo_perr_q;
  // XOR over data plus stored parity bit is 1 exactly when even parity broke.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_word[DATA_W-1:0];
      fifo_perr_q[wr_ptr_q] <= ^push_word;
    end
  end
  assign rsp_perr = bus.rsp_valid & fifo_perr_q[rd_ptr_q];
`else
  always_ff @(posedge clock) begin
    if (push) fifo_data_q[wr_ptr_q] <= push_word[DATA_W-1:0];
  end
`endif

  assign bus.rsp_data = bus.rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_mem_gen_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_gen_bank_ctrl
// Directed scenarios plus a randomized phase for mem_gen_bank_ctrl, checked
// every cycle against a transaction-level model (flat memory array plus an
// ordered queue of pending responses with their availability edge).
// ---------------------------------------------------------------------------
module tb_mem_gen_bank_ctrl;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 10;
  localparam int NUM_BANKS = 4;
  localparam int RD_LAT    = 2;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int SWEEP     = DEPTH / NUM_BANKS;
  localparam int RSP_DEPTH = RD_LAT + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic init_done, dbg_state;
`ifdef MEM_GEN_PARITY_EN
  logic rsp_perr;
`endif

  always #5 clk = ~clk;

  mem_gen_bank_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_gen_bank_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS), .RD_LAT(RD_LAT)
  ) dut (
    .clock(clk),
    .reset_n(reset_n),
    .bus(bus),
    .init_done(init_done),
`ifdef MEM_GEN_PARITY_EN
    .rsp_perr(rsp_perr),
`endif
    .dbg_state_o(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_aaaa_pops = 0;
  int n_valid_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] m_mem  [DEPTH];
  bit                m_perr [DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  int                exp_avail_q[$];
  bit                exp_perr_q[$];
  bit m_live  = 0;
  bit m_rst   = 0;
  int m_edges = 0;   // edges with reset_n high since the last reset edge

  always @(negedge clk) begin
    bit run, er, ev;
    run = 0; er = 0; ev = 0;
    if (m_live) begin
      run = (m_edges >= SWEEP);
      er  = run && (exp_q.size() < RSP_DEPTH);
      ev  = (exp_q.size() > 0) && (exp_avail_q[0] <= m_edges);
      check("init_done", init_done, run);
      check("dbg_state", dbg_state, run);
      check("req_ready", bus.req_ready, er);
      check("rsp_valid", bus.rsp_valid, ev);
      if (ev) check("rsp_data", bus.rsp_data, exp_q[0]);
`ifdef MEM_GEN_PARITY_EN
      check("rsp_perr", rsp_perr, ev ? exp_perr_q[0] : 1'b0);
`endif
      if (m_rst) check("rsp_data_reset", bus.rsp_data, 0);
      if (bus.rsp_valid) n_valid_seen++;
      if (bus.rsp_valid && bus.rsp_ready && bus.rsp_data == 16'hAAAA) n_aaaa_pops++;
    end
    // advance the model over the upcoming rising edge
    if (!reset_n) begin
      m_live  = 1;
      m_rst   = 1;
      m_edges = 0;
      exp_q.delete();
      exp_avail_q.delete();
      exp_perr_q.delete();
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = '0;
        m_perr[i] = 0;
      end
    end else if (m_live) begin
      m_rst = 0;
      if (ev && bus.rsp_ready) begin
        void'(exp_q.pop_front());
        void'(exp_avail_q.pop_front());
        void'(exp_perr_q.pop_front());
      end
      if (er && bus.req_valid) begin
        if (bus.req_wr) begin
          m_mem[bus.req_addr]  = bus.req_wdata;
          m_perr[bus.req_addr] = 0;
        end else begin
          exp_q.push_back(m_mem[bus.req_addr]);
          exp_avail_q.push_back(m_edges + 1 + RD_LAT);
          exp_perr_q.push_back(m_perr[bus.req_addr]);
        end
      end
      m_edges++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    bit acc;
    acc = 0;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
    check("req_accept_timeout", acc, 1);
  endtask

  // lat = edges after the accept edge before rsp_valid is seen
  task automatic wait_rsp(output int lat, output logic [DATA_W-1:0] data, output logic perr);
    bit got;
    got = 0; lat = 0; data = '0; perr = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got  = 1;
        data = bus.rsp_data;
`ifdef MEM_GEN_PARITY_EN
        perr = rsp_perr;
`endif
      end else begin
        lat++;
      end
      tick();
    end
    check("rsp_wait_timeout", got, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int n_acc;
    bit acc_now;
    bit pend;
    logic [DATA_W-1:0] d;
    logic p;

    bus.req_valid = 0; bus.req_wr = 0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1;
    reset_n = 0;
    repeat (3) tick();
    reset_n = 1;

    // clear sweep: 256 edges of INIT
    for (int i = 1; i <= SWEEP; i++) begin
      tick();
      if (i == SWEEP - 1) begin
        check("sweep_ready_low", bus.req_ready, 0);
        check("sweep_not_done", init_done, 0);
      end
      if (i == SWEEP) begin
        check("sweep_done_256", init_done, 1);
        check("ready_after_sweep", bus.req_ready, 1);
      end
    end

    // top word reads back as cleared
    do_req(0, 10'h3FF, '0);
    wait_rsp(lat, d, p);
    check("rd_3ff_cleared", d, 16'h0000);

    // read-after-write and minimum latency
    do_req(1, 10'h005, 16'h1234);
    do_req(0, 10'h005, '0);
    wait_rsp(lat, d, p);
    check("raw_data", d, 16'h1234);
    check("raw_latency_edges", lat + 1, 3);

`ifdef MEM_GEN_PARITY_EN
    // corrupt the stored word for 0x005 (bank 1, row 1)
    dut.mem_q[1][1][0] = ~dut.mem_q[1][1][0];
    m_mem[5]  = 16'h1235;
    m_perr[5] = 1;
    do_req(0, 10'h005, '0);
    wait_rsp(lat, d, p);
    check("perr_data", d, 16'h1235);
    check("perr_flag", p, 1);
    do_req(0, 10'h3FF, '0);
    wait_rsp(lat, d, p);
    check("perr_clean", p, 0);
`endif

    // stalled consumer: credits limit back-to-back reads to RSP_DEPTH
    bus.rsp_ready = 0;
    n_acc = 0;
    bus.req_valid = 1; bus.req_wr = 0;
    bus.req_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc_now = bus.req_ready;
      tick();
      if (acc_now) begin
        n_acc++;
        bus.req_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      end
    end
    bus.req_valid = 0;
    check("b2b_accepted", n_acc, 3);
    check("b2b_ready_low", bus.req_ready, 0);
    bus.rsp_ready = 1;
    tick();
    check("credit_return", bus.req_ready, 1);
    repeat (6) tick();

    // one word per bank, read back with a toggling consumer
    for (int i = 0; i < 4; i++) do_req(1, ADDR_W'(16 + i), 16'hAAAA);
    n_aaaa_pops = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) do_req(0, ADDR_W'(16 + i), '0);
      end
      begin
        for (int i = 0; i < 30; i++) begin
          bus.rsp_ready = ~bus.rsp_ready;
          tick();
        end
      end
    join
    bus.rsp_ready = 1;
    repeat (6) tick();
    check("aaaa_pops", n_aaaa_pops, 4);

    // reset with two reads in flight
    do_req(0, 10'h005, '0);
    do_req(0, 10'h006, '0);
    reset_n = 0;
    tick();
    reset_n = 1;
    n_valid_seen = 0;
    for (int i = 1; i <= SWEEP; i++) tick();
    check("no_rsp_after_reset", n_valid_seen, 0);
    check("resweep_done", init_done, 1);
    do_req(0, 10'h005, '0);
    wait_rsp(lat, d, p);
    check("cleared_005", d, 16'h0000);

    // randomized traffic, biased toward a small address window for reuse
    pend = 0;
    for (int i = 0; i < 600; i++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 4) != 0);
        bus.req_wr    = ($urandom_range(0, 9) < 4);
        bus.req_addr  = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 15))
                                                    : ADDR_W'($urandom_range(0, DEPTH - 1));
        bus.req_wdata = DATA_W'($urandom_range(0, 65535));
      end
      bus.req_valid = pend;
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc_now = pend && bus.req_ready;
      tick();
      if (acc_now) pend = 0;
    end
    bus.req_valid = 0;
    bus.rsp_ready = 1;
    repeat (10) tick();
    check("drain_empty", bus.rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
